// File: rtl/sync_fifo_stream_reader_if.sv
// FIFO read-port and valid/ready stream bundle for sync_fifo_stream_reader.
// master = the reader (pops the FIFO, drives the stream); slave = FIFO plus consumer.
interface sync_fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_read_o;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_rd_data_i,
        input  m_ready_i,
        output fifo_read_o,
        output m_valid_o,
        output m_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_rd_data_i,
        output m_ready_i,
        input  fifo_read_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream through a small
// skid buffer that hides the FIFO read latency (0 cycles FWFT, 1 cycle standard).
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter bit FWFT       = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,
    output logic [1:0]                buf_count_o,
    sync_fifo_stream_reader_if.master bus
);
    localparam logic [1:0] BUF_DEPTH = FWFT ? 2'd2 : 2'd3;

    logic [DATA_WIDTH-1:0] mem_q [3];
    logic [DATA_WIDTH-1:0] mem_d [3];
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [1:0]            occ_q,  occ_d;
    logic                  pend_q, pend_d;
    logic                  rd_issue;
    logic                  cap;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == BUF_DEPTH - 2'd1) ? 2'd0 : p + 2'd1;
    endfunction

    // Read issue depends only on registered state and the FIFO flag, so m_ready_i
    // never reaches fifo_read_o; an in-flight word reserves its slot via pend.
    always_comb begin
        rd_issue = rst_n_i && !bus.fifo_empty_i && !flush_i &&
                   (({1'b0, occ_q} + {2'b00, pend_q}) < {1'b0, BUF_DEPTH});
        cap      = FWFT ? rd_issue : pend_q;
        pop      = (occ_q != 2'd0) && bus.m_ready_i;
    end

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        pend_d = FWFT ? 1'b0 : rd_issue;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (cap) begin
                mem_d[tail_q] = bus.fifo_rd_data_i;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            occ_d = occ_q + {1'b0, cap} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q  <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            pend_q <= pend_d;
        end
    end

    assign bus.fifo_read_o = rd_issue;
    assign bus.m_valid_o   = (occ_q != 2'd0);
    assign bus.m_data_o    = mem_q[head_q];
    assign buf_count_o     = occ_q;
endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: one FWFT and one standard-mode reader, each
// fed by a registered-flag FIFO model and checked against an in-order scoreboard.
module tb_sync_fifo_stream_reader;
    localparam int DW = 32;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       flush_f = 1'b0;
    logic       flush_s = 1'b0;
    logic       ready_f = 1'b0;
    logic       ready_s = 1'b0;
    logic [1:0] cnt_f;
    logic [1:0] cnt_s;

    int vectors     = 0;
    int miscompares = 0;

    sync_fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus_f ();
    sync_fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus_s ();

    sync_fifo_stream_reader #(.DATA_WIDTH(DW), .FWFT(1'b1)) u_dut_f (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush_f),
        .buf_count_o(cnt_f),
        .bus        (bus_f.master)
    );

    sync_fifo_stream_reader #(.DATA_WIDTH(DW), .FWFT(1'b0)) u_dut_s (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush_s),
        .buf_count_o(cnt_s),
        .bus        (bus_s.master)
    );

    always #5 clk = ~clk;

    // FIFO models: storage never resets so a non-empty FIFO can be held across reset
    logic [DW-1:0] fm_f [128];
    logic [DW-1:0] fm_s [128];
    int            fw_f = 0, fr_f = 0, fw_s = 0, fr_s = 0;
    logic          empty_f = 1'b1;
    logic          empty_s = 1'b1;
    logic [DW-1:0] rdata_s = '0;
    logic [DW-1:0] exp_f [$];
    logic [DW-1:0] exp_s [$];

    assign bus_f.fifo_empty_i   = empty_f;
    assign bus_s.fifo_empty_i   = empty_s;
    assign bus_f.fifo_rd_data_i = fm_f[fr_f % 128];
    assign bus_s.fifo_rd_data_i = rdata_s;
    assign bus_f.m_ready_i      = ready_f;
    assign bus_s.m_ready_i      = ready_s;

    always @(posedge clk) begin
        if (bus_f.fifo_read_o && fr_f < fw_f) fr_f <= fr_f + 1;
        empty_f <= (fw_f == fr_f + ((bus_f.fifo_read_o && fr_f < fw_f) ? 1 : 0));
    end

    always @(posedge clk) begin
        if (bus_s.fifo_read_o && fr_s < fw_s) begin
            rdata_s <= fm_s[fr_s % 128];
            fr_s    <= fr_s + 1;
        end
        empty_s <= (fw_s == fr_s + ((bus_s.fifo_read_o && fr_s < fw_s) ? 1 : 0));
    end

    task automatic push_f(input logic [DW-1:0] w);
        fm_f[fw_f % 128] = w;
        fw_f++;
        exp_f.push_back(w);
    endtask

    task automatic push_s(input logic [DW-1:0] w);
        fm_s[fw_s % 128] = w;
        fw_s++;
        exp_s.push_back(w);
    endtask

    // Words buffered or in flight when the reader lost its state never reach the consumer
    task automatic trim_expected();
        while (exp_f.size() > fw_f - fr_f) void'(exp_f.pop_front());
        while (exp_s.size() > fw_s - fr_s) void'(exp_s.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : mon_f
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                vectors++;
                if (bus_f.fifo_read_o && bus_f.fifo_empty_i) begin
                    miscompares++;
                    $display("FAIL read_while_empty_f: fifo_read_o=1 while fifo_empty_i=1, required 0");
                end
                vectors++;
                if (cnt_f > 2'd2 || bus_f.m_valid_o !== (cnt_f != 2'd0)) begin
                    miscompares++;
                    $display("FAIL count_f: buf_count_o=%0d m_valid_o=%b, required <=2 and valid==(count!=0)",
                             cnt_f, bus_f.m_valid_o);
                end
                if (bus_f.m_valid_o && ready_f) begin
                    vectors++;
                    if (exp_f.size() == 0) begin
                        miscompares++;
                        $display("FAIL stream_f: got %h, required no word", bus_f.m_data_o);
                    end else begin
                        e = exp_f.pop_front();
                        if (bus_f.m_data_o !== e) begin
                            miscompares++;
                            $display("FAIL stream_f: got %h, required %h", bus_f.m_data_o, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : mon_s
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                vectors++;
                if (bus_s.fifo_read_o && bus_s.fifo_empty_i) begin
                    miscompares++;
                    $display("FAIL read_while_empty_s: fifo_read_o=1 while fifo_empty_i=1, required 0");
                end
                vectors++;
                if (cnt_s > 2'd3 || bus_s.m_valid_o !== (cnt_s != 2'd0)) begin
                    miscompares++;
                    $display("FAIL count_s: buf_count_o=%0d m_valid_o=%b, required <=3 and valid==(count!=0)",
                             cnt_s, bus_s.m_valid_o);
                end
                if (bus_s.m_valid_o && ready_s) begin
                    vectors++;
                    if (exp_s.size() == 0) begin
                        miscompares++;
                        $display("FAIL stream_s: got %h, required no word", bus_s.m_data_o);
                    end else begin
                        e = exp_s.pop_front();
                        if (bus_s.m_data_o !== e) begin
                            miscompares++;
                            $display("FAIL stream_s: got %h, required %h", bus_s.m_data_o, e);
                        end
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        step();
        ready_f = 1'b1;
        ready_s = 1'b1;
        while ((exp_f.size() != 0 || exp_s.size() != 0) && n < 200) begin
            step();
            n++;
        end
        repeat (3) step();
        vectors++;
        if (exp_f.size() != 0 || exp_s.size() != 0 || bus_f.m_valid_o !== 1'b0 || bus_s.m_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_%s: left f=%0d s=%0d valid f=%b s=%b, required 0 0 0 0",
                     name, exp_f.size(), exp_s.size(), bus_f.m_valid_o, bus_s.m_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ready_f = 1'b1;
        ready_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_f(32'hA0 + k);
            push_s(32'hB0 + k);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (bus_f.fifo_read_o !== 1'b0 || bus_s.fifo_read_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read: fifo_read_o f=%b s=%b, required 0 0", bus_f.fifo_read_o, bus_s.fifo_read_o);
        end
        if (bus_f.m_valid_o !== 1'b0 || bus_s.m_valid_o !== 1'b0 || cnt_f !== 2'd0 || cnt_s !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid f=%b s=%b count f=%0d s=%0d, required 0 0 0 0",
                     bus_f.m_valid_o, bus_s.m_valid_o, cnt_f, cnt_s);
        end
        vectors++;
        if (bus_f.m_data_o !== '0 || bus_s.m_data_o !== '0) begin
            miscompares++;
            $display("FAIL reset_data: m_data_o f=%h s=%h, required 0 0", bus_f.m_data_o, bus_s.m_data_o);
        end
        rst_n = 1'b1;
        drain("reset");
    endtask

    task automatic test_fwft_stream();
        logic [DW-1:0] w [4];
        w = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int k = 0; k < 4; k++) push_f(w[k]);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_f.fifo_read_o !== (i < 4) || bus_f.m_valid_o !== (i >= 1 && i <= 4)) begin
                miscompares++;
                $display("FAIL fwft_timing[%0d]: read=%b valid=%b, required %b %b",
                         i, bus_f.fifo_read_o, bus_f.m_valid_o, (i < 4), (i >= 1 && i <= 4));
            end
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (bus_f.m_data_o !== w[i-1]) begin
                    miscompares++;
                    $display("FAIL fwft_data[%0d]: got %h, required %h", i, bus_f.m_data_o, w[i-1]);
                end
            end
        end
        drain("fwft");
    endtask

    task automatic test_std_stream();
        logic [DW-1:0] w [4];
        w = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int k = 0; k < 4; k++) push_s(w[k]);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_s.fifo_read_o !== (i < 4) || bus_s.m_valid_o !== (i >= 2 && i <= 5)) begin
                miscompares++;
                $display("FAIL std_timing[%0d]: read=%b valid=%b, required %b %b",
                         i, bus_s.fifo_read_o, bus_s.m_valid_o, (i < 4), (i >= 2 && i <= 5));
            end
            if (i >= 2 && i <= 5) begin
                vectors++;
                if (bus_s.m_data_o !== w[i-2]) begin
                    miscompares++;
                    $display("FAIL std_data[%0d]: got %h, required %h", i, bus_s.m_data_o, w[i-2]);
                end
            end
        end
        drain("std");
    endtask

    task automatic test_backpressure();
        int reads;
        reads   = 0;
        ready_s = 1'b0;
        for (int k = 0; k < 8; k++) push_s(32'h100 + k);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_s.fifo_read_o) reads++;
        end
        vectors++;
        if (reads != 3 || cnt_s !== 2'd3) begin
            miscompares++;
            $display("FAIL bp_fill: reads=%0d count=%0d, required 3 3", reads, cnt_s);
        end
        vectors++;
        if (bus_s.m_valid_o !== 1'b1 || bus_s.m_data_o !== 32'h100) begin
            miscompares++;
            $display("FAIL bp_hold: valid=%b data=%h, required 1 00000100", bus_s.m_valid_o, bus_s.m_data_o);
        end
        drain("backpressure");
    endtask

    task automatic test_flush();
        int unsigned n;
        ready_s = 1'b1;
        for (int k = 0; k < 5; k++) push_s(32'h200 + k);
        @(posedge clk);
        @(posedge clk);
        #1;
        flush_s = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_s.fifo_read_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_blocks_read: fifo_read_o=%b, required 0", bus_s.fifo_read_o);
        end
        step();
        flush_s = 1'b0;
        trim_expected();
        @(negedge clk);
        vectors++;
        if (bus_s.m_valid_o !== 1'b0 || cnt_s !== 2'd0) begin
            miscompares++;
            $display("FAIL flush_pend: valid=%b count=%0d, required 0 0", bus_s.m_valid_o, cnt_s);
        end
        n = 0;
        while (bus_s.m_valid_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus_s.m_valid_o !== 1'b1 || bus_s.m_data_o !== 32'h201) begin
            miscompares++;
            $display("FAIL flush_next: valid=%b data=%h, required 1 00000201", bus_s.m_valid_o, bus_s.m_data_o);
        end
        drain("flush_s");

        ready_f = 1'b0;
        for (int k = 0; k < 3; k++) push_f(32'h400 + k);
        repeat (5) step();
        @(negedge clk);
        vectors++;
        if (cnt_f !== 2'd2 || bus_f.fifo_read_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fwft_full: count=%0d read=%b, required 2 0", cnt_f, bus_f.fifo_read_o);
        end
        step();
        flush_f = 1'b1;
        step();
        flush_f = 1'b0;
        trim_expected();
        @(negedge clk);
        vectors++;
        if (bus_f.m_valid_o !== 1'b0 || cnt_f !== 2'd0) begin
            miscompares++;
            $display("FAIL flush_f: valid=%b count=%0d, required 0 0", bus_f.m_valid_o, cnt_f);
        end
        drain("flush_f");
    endtask

    task automatic test_reset_mid();
        ready_s = 1'b0;
        for (int k = 0; k < 4; k++) push_s(32'h300 + k);
        repeat (6) step();
        @(negedge clk);
        vectors++;
        if (cnt_s !== 2'd3) begin
            miscompares++;
            $display("FAIL midreset_pre: count=%0d, required 3", cnt_s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_s.m_valid_o !== 1'b0 || cnt_s !== 2'd0 || bus_s.fifo_read_o !== 1'b0 || bus_s.m_data_o !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: valid=%b count=%0d read=%b data=%h, required 0 0 0 0",
                     bus_s.m_valid_o, cnt_s, bus_s.fifo_read_o, bus_s.m_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        trim_expected();
        drain("midreset");
    endtask

    task automatic test_wrap();
        int unsigned n;
        for (int k = 0; k < 20; k++) begin
            push_f($urandom);
            push_s($urandom);
        end
        n = 0;
        while ((exp_f.size() != 0 || exp_s.size() != 0) && n < 400) begin
            step();
            ready_f = 1'($urandom_range(0, 1));
            ready_s = 1'($urandom_range(0, 1));
            n++;
        end
        drain("wrap");
    endtask

    initial begin
        test_reset();
        test_fwft_stream();
        test_std_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
